// File: rtl/vector_frame_accumulator_if.sv
// Vector/frame bus for the vector frame accumulator: input vectors, frame qualifiers,
// firmware write bus and the registered result.
interface vector_frame_accumulator_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = $clog2(MAX_CHAINS);

  logic                  tracing;
  logic                  valid_in;
  logic                  bof_in;
  logic                  eof_in;
  logic [CW-1:0]         chainId_in;
  logic [DATA_WIDTH-1:0] vector_in [N];
  logic [7:0]            configId;
  logic [7:0]            configData;

  logic                  valid_out;
  logic                  bof_out;
  logic                  eof_out;
  logic [CW-1:0]         chainId_out;
  logic [DATA_WIDTH-1:0] vector_out [N];

  modport master (
    output tracing, valid_in, bof_in, eof_in, chainId_in, vector_in, configId, configData,
    input  valid_out, bof_out, eof_out, chainId_out, vector_out
  );

  modport slave (
    input  tracing, valid_in, bof_in, eof_in, chainId_in, vector_in, configId, configData,
    output valid_out, bof_out, eof_out, chainId_out, vector_out
  );
endinterface

// File: rtl/vector_frame_accumulator.sv
// Per-chain lane-wise frame accumulator: enabled chains sum vectors from bof to eof
// and emit one result; disabled chains pass vectors straight through.
module vector_frame_accumulator #(
  parameter int         N                  = 8,
  parameter int         DATA_WIDTH         = 32,
  parameter int         MAX_CHAINS         = 4,
  parameter logic [7:0] INITIAL_FIRMWARE   = 8'h00,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'h00
) (
  input logic                       clk,
  input logic                       rst_n,
  vector_frame_accumulator_if.slave bus
);
  localparam int CW = $clog2(MAX_CHAINS);
  typedef logic [DATA_WIDTH-1:0] lane_t;

  function automatic lane_t lane_add(input lane_t a, input lane_t b);
    return a + b;
  endfunction

  logic [7:0]            enable_q;
  logic [MAX_CHAINS-1:0] open_q;
  lane_t                 acc_q [MAX_CHAINS][N];

  logic                  vld_p1;
  logic                  bof_p1;
  logic                  eof_p1;
  logic [CW-1:0]         chain_p1;
  lane_t                 vec_p1 [N];

  logic [CW-1:0]         chain;
  logic [7:0]            en_shift;
  logic [MAX_CHAINS-1:0] open_shift;
  logic                  accept;
  logic                  acc_mode;
  logic                  restart;
  logic                  cfg_hit;
  lane_t                 sum [N];

  assign chain      = bus.chainId_in;
  assign en_shift   = enable_q >> chain;
  assign open_shift = open_q >> chain;
  assign acc_mode   = en_shift[0];
  // A closed chain treats any vector as the start of a new frame.
  assign restart    = bus.bof_in || !open_shift[0];
  assign cfg_hit    = (bus.configId == PERSONAL_CONFIG_ID);
  assign accept     = bus.valid_in && bus.tracing && (32'(chain) < MAX_CHAINS);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sum[i] = lane_add(restart ? lane_t'(0) : acc_q[chain][i], bus.vector_in[i]);
    end
  end

  // Stage p0 -> p1: accumulator update and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= INITIAL_FIRMWARE;
      open_q   <= '0;
      vld_p1   <= 1'b0;
      bof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      chain_p1 <= '0;
      for (int i = 0; i < N; i++) begin
        vec_p1[i] <= '0;
      end
      for (int c = 0; c < MAX_CHAINS; c++) begin
        for (int i = 0; i < N; i++) begin
          acc_q[c][i] <= '0;
        end
      end
    end else begin
      vld_p1   <= 1'b0;
      bof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      chain_p1 <= '0;
      for (int i = 0; i < N; i++) begin
        vec_p1[i] <= '0;
      end

      if (accept) begin
        if (acc_mode) begin
          for (int i = 0; i < N; i++) begin
            acc_q[chain][i] <= sum[i];
          end
          open_q[chain] <= !bus.eof_in;
          if (bus.eof_in) begin
            vld_p1   <= 1'b1;
            bof_p1   <= 1'b1;
            eof_p1   <= 1'b1;
            chain_p1 <= chain;
            for (int i = 0; i < N; i++) begin
              vec_p1[i] <= sum[i];
            end
          end
        end else begin
          vld_p1   <= 1'b1;
          bof_p1   <= bus.bof_in;
          eof_p1   <= bus.eof_in;
          chain_p1 <= chain;
          for (int i = 0; i < N; i++) begin
            vec_p1[i] <= bus.vector_in[i];
          end
        end
      end

      // Disabling a chain also abandons its open frame on the same edge.
      if (cfg_hit) begin
        enable_q <= bus.configData;
        for (int c = 0; c < MAX_CHAINS; c++) begin
          if (!bus.configData[c]) begin
            open_q[c] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.valid_out   = vld_p1;
  assign bus.bof_out     = bof_p1;
  assign bus.eof_out     = eof_p1;
  assign bus.chainId_out = chain_p1;
  assign bus.vector_out  = vec_p1;
endmodule

// File: tb/tb_vector_frame_accumulator.sv
// Self-checking bench for vector_frame_accumulator: directed scenarios plus randomized
// traffic against a frame-list reference model.
module tb_vector_frame_accumulator;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int MC = 3;
  localparam int CW = 2;
  localparam logic [7:0] INIT_FW = 8'h02;
  localparam logic [7:0] PCID    = 8'h5A;
  localparam logic [7:0] IDLE_ID = 8'hFF;

  typedef logic [N*DW-1:0]      pvec_t;
  typedef logic [3+CW+N*DW-1:0] out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vector_frame_accumulator_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();

  vector_frame_accumulator #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC),
    .INITIAL_FIRMWARE(INIT_FW), .PERSONAL_CONFIG_ID(PCID)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // Reference model: enable byte plus, per chain, the list of vectors in the open frame.
  logic [7:0] m_en;
  pvec_t      frame_q [MC][$];
  out_t       exp_out;

  function automatic out_t pack_out(input logic v, input logic b, input logic e,
                                    input logic [CW-1:0] c, input pvec_t vec);
    return {v, b, e, c, vec};
  endfunction

  function automatic out_t dut_out();
    pvec_t v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = bus.vector_out[i];
    return {bus.valid_out, bus.bof_out, bus.eof_out, bus.chainId_out, v};
  endfunction

  function automatic pvec_t splat(input logic [DW-1:0] x);
    pvec_t v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = x;
    return v;
  endfunction

  function automatic pvec_t rand_vec();
    pvec_t v;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    return v;
  endfunction

  function automatic pvec_t frame_sum(input int ch);
    pvec_t s = '0;
    for (int k = 0; k < frame_q[ch].size(); k++)
      for (int l = 0; l < N; l++)
        s[l*DW +: DW] = s[l*DW +: DW] + frame_q[ch][k][l*DW +: DW];
    return s;
  endfunction

  function automatic void model_reset();
    m_en = INIT_FW;
    for (int c = 0; c < MC; c++) frame_q[c].delete();
  endfunction

  function automatic void model_step(input logic v, input logic t, input logic b, input logic e,
                                     input logic [CW-1:0] ch, input pvec_t vec,
                                     input logic [7:0] cid, input logic [7:0] cdat);
    int c;
    c = int'(ch);
    exp_out = '0;
    if (v && t && c < MC) begin
      if (!m_en[c]) begin
        exp_out = pack_out(1'b1, b, e, ch, vec);
      end else begin
        if (b) frame_q[c].delete();
        frame_q[c].push_back(vec);
        if (e) begin
          exp_out = pack_out(1'b1, 1'b1, 1'b1, ch, frame_sum(c));
          frame_q[c].delete();
        end
      end
    end
    if (cid == PCID) begin
      for (int k = 0; k < MC; k++) if (!cdat[k]) frame_q[k].delete();
      m_en = cdat;
    end
  endfunction

  task automatic idle();
    bus.tracing = 1'b1; bus.valid_in = 1'b0; bus.bof_in = 1'b0; bus.eof_in = 1'b0;
    bus.chainId_in = '0; bus.configId = IDLE_ID; bus.configData = 8'h00;
    for (int i = 0; i < N; i++) bus.vector_in[i] = '0;
  endtask

  task automatic apply(input logic v, input logic t, input logic b, input logic e,
                       input logic [CW-1:0] ch, input pvec_t vec,
                       input logic [7:0] cid, input logic [7:0] cdat);
    @(negedge clk);
    bus.valid_in = v; bus.tracing = t; bus.bof_in = b; bus.eof_in = e;
    bus.chainId_in = ch; bus.configId = cid; bus.configData = cdat;
    for (int i = 0; i < N; i++) bus.vector_in[i] = vec[i*DW +: DW];
    model_step(v, t, b, e, ch, vec, cid, cdat);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic e, input logic [CW-1:0] ch, input pvec_t vec);
    apply(1'b1, 1'b1, b, e, ch, vec, IDLE_ID, 8'h00);
  endtask

  task automatic cfg(input logic [7:0] d);
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, PCID, d);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", dut_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Enable register comes up at INIT_FW = 0x02: chain 1 accumulates, chain 0 passes.
    send(1'b1, 1'b0, 2'd1, splat(32'd10));
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL init_fw_open got valid %b want 0", bus.valid_out);
    end
    send(1'b0, 1'b1, 2'd1, splat(32'd20));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd1, splat(32'd30))) begin
      errors++; $display("FAIL init_fw_sum got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b1, 2'd1, splat(32'd30)));
    end
    send(1'b0, 1'b0, 2'd0, splat(32'd9));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b0, 1'b0, 2'd0, splat(32'd9))) begin
      errors++; $display("FAIL init_fw_pass got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b0, 1'b0, 2'd0, splat(32'd9)));
    end
  endtask

  task automatic test_frame_sum();
    cfg(8'h01);
    send(1'b1, 1'b0, 2'd0, splat(32'd1));
    send(1'b0, 1'b0, 2'd0, splat(32'd2));
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL frame_mid got valid %b want 0", bus.valid_out);
    end
    send(1'b0, 1'b1, 2'd0, splat(32'd3));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd6))) begin
      errors++; $display("FAIL frame_sum got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd6)));
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, IDLE_ID, 8'h00);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL frame_after got valid %b want 0", bus.valid_out);
    end
  endtask

  task automatic test_passthrough();
    pvec_t ramp;
    for (int i = 0; i < N; i++) ramp[i*DW +: DW] = 32'(i);
    cfg(8'h00);
    send(1'b1, 1'b0, 2'd2, ramp);
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b0, 2'd2, ramp)) begin
      errors++; $display("FAIL passthrough got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b0, 2'd2, ramp));
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] v1 [4];
    v1[0] = 32'hFFFF_FFFF; v1[1] = 32'd1; v1[2] = 32'hFFFF_FFFF; v1[3] = 32'd1;
    cfg(8'h03);
    for (int k = 0; k < 4; k++) begin
      send(k == 0, k == 3, 2'd0, splat(32'hFFFF_FFFF));
      checks++;
      if (dut_out() !== exp_out) begin
        errors++; $display("FAIL wrap_ch0_%0d got %h want %h", k, dut_out(), exp_out);
      end
      send(k == 0, k == 3, 2'd1, splat(v1[k]));
      checks++;
      if (dut_out() !== exp_out) begin
        errors++; $display("FAIL wrap_ch1_%0d got %h want %h", k, dut_out(), exp_out);
      end
      if (k == 3) begin
        checks++;
        if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd1, splat(32'd0))) begin
          errors++; $display("FAIL wrap_zero got %h", dut_out());
        end
      end
    end
    checks++;
    if (exp_out[N*DW-1:0] !== splat(32'd0)) begin
      errors++; $display("FAIL wrap_model got %h want 0", exp_out[N*DW-1:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    cfg(8'h01);
    send(1'b1, 1'b0, 2'd0, splat(32'd5));
    send(1'b1, 1'b1, 2'd2, splat(32'd44));
    checks++;
    if (bus.valid_out !== 1'b1) begin
      errors++; $display("FAIL prereset_valid got %b want 1", bus.valid_out);
    end
    idle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL async_reset got %h want 0", dut_out());
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL held_reset got %h want 0", dut_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
    cfg(8'h01);
    send(1'b0, 1'b1, 2'd0, splat(32'd7));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd7))) begin
      errors++; $display("FAIL reset_discard got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd7)));
    end
  endtask

  task automatic test_tracing();
    cfg(8'h01);
    send(1'b1, 1'b0, 2'd0, splat(32'd2));
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, rand_vec(), IDLE_ID, 8'h00);
      checks++;
      if (bus.valid_out !== 1'b0) begin
        errors++; $display("FAIL tracing_off_%0d got valid %b want 0", k, bus.valid_out);
      end
    end
    send(1'b0, 1'b1, 2'd0, splat(32'd4));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd6))) begin
      errors++; $display("FAIL tracing_sum got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd6)));
    end
  endtask

  task automatic test_config_mid_frame();
    cfg(8'h01);
    send(1'b1, 1'b0, 2'd0, splat(32'd3));
    cfg(8'h00);
    send(1'b0, 1'b1, 2'd0, splat(32'd4));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b0, 1'b1, 2'd0, splat(32'd4))) begin
      errors++; $display("FAIL cfg_pass got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b0, 1'b1, 2'd0, splat(32'd4)));
    end
    cfg(8'h01);
    send(1'b0, 1'b1, 2'd0, splat(32'd8));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd8))) begin
      errors++; $display("FAIL cfg_reopen got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd8)));
    end
  endtask

  task automatic test_bad_chain();
    cfg(8'h07);
    send(1'b1, 1'b0, 2'd0, splat(32'd11));
    send(1'b1, 1'b1, 2'd3, splat(32'd99));
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL bad_chain got %h want 0", dut_out());
    end
    send(1'b0, 1'b1, 2'd0, splat(32'd12));
    checks++;
    if (dut_out() !== pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd23))) begin
      errors++; $display("FAIL bad_chain_sum got %h want %h", dut_out(),
                         pack_out(1'b1, 1'b1, 1'b1, 2'd0, splat(32'd23)));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cid;
    logic [7:0] cdat;
    for (int n = 0; n < 600; n++) begin
      cid  = IDLE_ID;
      cdat = 8'($urandom);
      case ($urandom_range(0, 15))
        0: cid = PCID;
        1: begin
          cid = 8'($urandom);
          if (cid == PCID) cid = ~PCID;
        end
        default: ;
      endcase
      apply($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), rand_vec(), cid, cdat);
      checks++;
      if (dut_out() !== exp_out) begin
        errors++; $display("FAIL random_%0d got %h want %h", n, dut_out(), exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_sum();
    test_passthrough();
    test_wrap();
    test_reset_mid_frame();
    test_tracing();
    test_config_mid_frame();
    test_bad_chain();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
